// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the 5-stage pipeline hazard sequencer.
package pipeline_pkg;

  typedef enum logic [1:0] {RUN, FLUSH, IO_WAIT} hazard_state_t;

  localparam int REGADDRWIDTH       = 4;
  localparam int IO_TIMEOUT_DEFAULT = 255;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard-sequencer signal bundle: per-stage hazard inputs, IO handshake, stall/flush enables.
interface hazard_sequencer_if #(
  parameter int REGADDRWIDTH = pipeline_pkg::REGADDRWIDTH
);
  logic                    takeBranchE;
  logic                    writeEnableE;
  logic                    resultSelectorWBE;
  logic [REGADDRWIDTH-1:0] destRegE;
  logic [REGADDRWIDTH-1:0] srcReg1D;
  logic [REGADDRWIDTH-1:0] srcReg2D;
  logic                    outFlagIOM;
  logic                    ioAck;
  logic                    stallF, stallD, stallE, stallM;
  logic                    flushD, flushE;
  logic                    ioReq;
  logic                    ioTimeoutErr;

  modport master (
    output takeBranchE, writeEnableE, resultSelectorWBE, destRegE, srcReg1D, srcReg2D,
           outFlagIOM, ioAck,
    input  stallF, stallD, stallE, stallM, flushD, flushE, ioReq, ioTimeoutErr
  );

  modport slave (
    input  takeBranchE, writeEnableE, resultSelectorWBE, destRegE, srcReg1D, srcReg2D,
           outFlagIOM, ioAck,
    output stallF, stallD, stallE, stallM, flushD, flushE, ioReq, ioTimeoutErr
  );
endinterface

// File: rtl/hazard_sequencer_io_wait_timer.sv
// IO handshake watchdog: counts cycles in IO_WAIT, reports ack/timeout, keeps a sticky error.
module io_wait_timer #(
  parameter int IOTIMEOUT = pipeline_pkg::IO_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic ioAck,
  output logic done,
  output logic ioTimeoutErr
);
  import pipeline_pkg::*;

  localparam int            TW   = cnt_width(IOTIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(IOTIMEOUT - 1);

  logic [TW-1:0] timer;
  logic          at_last;

  assign at_last = (timer == LAST);
  // An ack landing on the final cycle wins over the timeout.
  assign done    = active & (ioAck | at_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      ioTimeoutErr <= 1'b0;
    end else begin
      if (start)
        timer <= '0;
      else if (active && !done)
        timer <= timer + TW'(1);
      if (active && !ioAck && at_last)
        ioTimeoutErr <= 1'b1;
    end
  end
endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the F/D/E/M/WB pipeline: load-use, taken-branch and IO freeze.
// Optional HAZARD_PERF_EN adds saturating stallCount/flushCount outputs.
module hazard_sequencer #(
  parameter int REGADDRWIDTH = pipeline_pkg::REGADDRWIDTH,
  parameter int FLUSHCYCLES  = 1,
  parameter int IOTIMEOUT    = pipeline_pkg::IO_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  hazard_sequencer_if.slave  hs
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]        stallCount,
  output logic [15:0]        flushCount
`endif
);
  import pipeline_pkg::*;

  localparam int            CW     = cnt_width(FLUSHCYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(FLUSHCYCLES - 1);

  hazard_state_t           state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [REGADDRWIDTH-1:0] rd_e, rs1_d, rs2_d;
  logic                    load_use, io_start, io_done, io_req, io_err;
  logic                    s_fd, s_em, f_d, f_e;

  assign rd_e     = hs.destRegE;
  assign rs1_d    = hs.srcReg1D;
  assign rs2_d    = hs.srcReg2D;
  assign load_use = hs.resultSelectorWBE & hs.writeEnableE & ((rd_e == rs1_d) | (rd_e == rs2_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      cnt    <= '0;
      io_req <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (io_start)
        io_req <= 1'b1;
      else if (io_done)
        io_req <= 1'b0;
    end
  end

  // IO freeze outranks branch, branch outranks load-use (Decode is wrong-path then).
  always_comb begin
    s_fd      = 1'b0;
    s_em      = 1'b0;
    f_d       = 1'b0;
    f_e       = 1'b0;
    io_start  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN, FLUSH: begin
        if (hs.outFlagIOM) begin
          s_fd      = 1'b1;
          s_em      = 1'b1;
          io_start  = 1'b1;
          state_nxt = IO_WAIT;
        end else if (hs.takeBranchE) begin
          f_d = 1'b1;
          f_e = 1'b1;
          if (FLUSHCYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = RELOAD;
          end
        end else if (state == FLUSH) begin
          f_d     = 1'b1;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1))
            state_nxt = RUN;
        end else if (load_use) begin
          s_fd = 1'b1;
          f_e  = 1'b1;
        end
      end
      IO_WAIT: begin
        s_fd = 1'b1;
        s_em = 1'b1;
        if (io_done)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  io_wait_timer #(.IOTIMEOUT(IOTIMEOUT)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .start        (io_start),
    .active       (state == IO_WAIT),
    .ioAck        (hs.ioAck),
    .done         (io_done),
    .ioTimeoutErr (io_err)
  );

  assign hs.stallF       = s_fd & ~reset;
  assign hs.stallD       = s_fd & ~reset;
  assign hs.stallE       = s_em & ~reset;
  assign hs.stallM       = s_em & ~reset;
  assign hs.flushD       = f_d  & ~reset;
  assign hs.flushE       = f_e  & ~reset;
  assign hs.ioReq        = io_req;
  assign hs.ioTimeoutErr = io_err;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (hs.stallF && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
      if ((hs.flushD || hs.flushE) && flushCount != 16'hFFFF)
        flushCount <= flushCount + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed vector table, hand sequences, random vs model.
module tb_hazard_sequencer;
  localparam int FC  = 2;
  localparam int IOT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_sequencer_if #(.REGADDRWIDTH(4)) hs ();

`ifdef HAZARD_PERF_EN
  logic [15:0] stallCount, flushCount;
`endif

  hazard_sequencer #(.REGADDRWIDTH(4), .FLUSHCYCLES(FC), .IOTIMEOUT(IOT)) dut (
    .clk   (clk),
    .reset (reset),
    .hs    (hs.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stallCount (stallCount),
    .flushCount (flushCount)
`endif
  );

  typedef struct {
    logic       rst, br, we, ld;
    logic [3:0] rd, rs1, rs2;
    logic       io, ack;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] exp;   // {stallF,stallD,stallE,stallM,flushD,flushE,ioReq,ioTimeoutErr}
  } vec_t;

  int checks = 0;
  int passed = 0;

  // Reference model: IO freeze flag with elapsed cycles, remaining flushD cycles, sticky error.
  bit m_io = 0;
  int m_io_cycles = 0;
  int m_flush_left = 0;
  bit m_err = 0;
  int m_sc = 0, m_fc = 0;

  function automatic in_t mk(logic rst, logic br, logic we, logic ld, logic [3:0] rd,
                             logic [3:0] rs1, logic [3:0] rs2, logic io, logic ack);
    in_t v;
    v.rst = rst; v.br = br; v.we = we; v.ld = ld;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.io = io; v.ack = ack;
    return v;
  endfunction

  task automatic drive(input in_t v);
    reset                = v.rst;
    hs.takeBranchE       = v.br;
    hs.writeEnableE      = v.we;
    hs.resultSelectorWBE = v.ld;
    hs.destRegE          = v.rd;
    hs.srcReg1D          = v.rs1;
    hs.srcReg2D          = v.rs2;
    hs.outFlagIOM        = v.io;
    hs.ioAck             = v.ack;
  endtask

  function automatic logic [7:0] outs();
    return {hs.stallF, hs.stallD, hs.stallE, hs.stallM, hs.flushD, hs.flushE,
            hs.ioReq, hs.ioTimeoutErr};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input int exp);
    checks++;
    if (act === 16'(exp)) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] model_out();
    logic lu;
    lu = hs.resultSelectorWBE & hs.writeEnableE &
         ((hs.destRegE == hs.srcReg1D) || (hs.destRegE == hs.srcReg2D));
    if (reset)                 return 8'b0000_0000;
    else if (m_io)             return {4'b1111, 2'b00, 1'b1, m_err};
    else if (hs.outFlagIOM)    return {4'b1111, 2'b00, 1'b0, m_err};
    else if (hs.takeBranchE)   return {4'b0000, 2'b11, 1'b0, m_err};
    else if (m_flush_left > 0) return {4'b0000, 2'b10, 1'b0, m_err};
    else if (lu)               return {4'b1100, 2'b01, 1'b0, m_err};
    else                       return {7'b0, m_err};
  endfunction

  task automatic model_clk();
    logic [7:0] e;
    e = model_out();
    if (reset) begin
      m_io = 0; m_io_cycles = 0; m_flush_left = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e[7] && m_sc < 65535) m_sc++;
      if ((e[3] || e[2]) && m_fc < 65535) m_fc++;
      if (m_io) begin
        if (hs.ioAck) m_io = 0;
        else if (m_io_cycles == IOT - 1) begin m_io = 0; m_err = 1; end
        else m_io_cycles++;
      end else if (hs.outFlagIOM) begin
        m_io = 1; m_io_cycles = 0; m_flush_left = 0;
      end else if (hs.takeBranchE) begin
        m_flush_left = FC - 1;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
    end
  endtask

  task automatic step(input string name, input in_t v, input logic [7:0] exp, input bit use_model);
    @(negedge clk);
    drive(v);
    #1;
    check8(name, outs(), use_model ? model_out() : exp);
`ifdef HAZARD_PERF_EN
    if (use_model) begin
      check16({name, " stallCount"}, stallCount, reset ? 0 : m_sc);
      check16({name, " flushCount"}, flushCount, reset ? 0 : m_fc);
    end
`endif
    model_clk();
  endtask

  vec_t tbl[$];
  in_t  idle, r;

  initial begin
    idle = mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    drive(mk(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0));

    tbl.push_back('{mk(1, 1, 1, 1, 4'd3, 4'd3, 4'd3, 1, 0), 8'b0000_0000}); // held in reset
    tbl.push_back('{idle,                                   8'b0000_0000});
    tbl.push_back('{mk(0, 0, 1, 1, 4'd3, 4'd1, 4'd3, 0, 0), 8'b1100_0100}); // load-use rs2
    tbl.push_back('{idle,                                   8'b0000_0000});
    tbl.push_back('{mk(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0), 8'b0000_1100}); // branch t0
    tbl.push_back('{idle,                                   8'b0000_1000}); // t1
    tbl.push_back('{idle,                                   8'b0000_0000}); // t2
    tbl.push_back('{mk(0, 1, 1, 1, 4'd5, 4'd5, 4'd0, 0, 0), 8'b0000_1100}); // branch + load-use
    tbl.push_back('{idle,                                   8'b0000_1000});
    tbl.push_back('{idle,                                   8'b0000_0000});
    tbl.push_back('{mk(0, 0, 0, 1, 4'd5, 4'd5, 4'd5, 0, 0), 8'b0000_0000}); // no write enable
    tbl.push_back('{mk(0, 0, 1, 0, 4'd5, 4'd5, 4'd5, 0, 0), 8'b0000_0000}); // not a load
    tbl.push_back('{mk(0, 0, 1, 1, 4'd7, 4'd6, 4'd8, 0, 0), 8'b0000_0000}); // no reg match
    tbl.push_back('{mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0), 8'b1111_0000}); // IO t0
    tbl.push_back('{idle,                                   8'b1111_0010}); // t1
    tbl.push_back('{idle,                                   8'b1111_0010});
    tbl.push_back('{idle,                                   8'b1111_0010});
    tbl.push_back('{mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1), 8'b1111_0010}); // ack t4
    tbl.push_back('{idle,                                   8'b0000_0000}); // t5
    tbl.push_back('{mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1), 8'b0000_0000}); // stray ack
    tbl.push_back('{mk(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0), 8'b0000_1100}); // branch
    tbl.push_back('{mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0), 8'b1111_0000}); // IO beats flush
    tbl.push_back('{mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1), 8'b1111_0010});
    tbl.push_back('{idle,                                   8'b0000_0000}); // flush abandoned
    tbl.push_back('{mk(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0), 8'b0000_1100});
    tbl.push_back('{mk(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0), 8'b0000_1100}); // restart in FLUSH
    tbl.push_back('{mk(0, 0, 1, 1, 4'd2, 4'd2, 4'd0, 0, 0), 8'b0000_1000}); // load-use masked
    tbl.push_back('{idle,                                   8'b0000_0000});

    foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].exp, 0);

    // IO timeout: eight IO_WAIT cycles without ack, then sticky error.
    step("to_enter", mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0), 8'b1111_0000, 0);
    for (int k = 0; k < IOT; k++) step($sformatf("to_wait%0d", k), idle, 8'b1111_0010, 0);
    for (int k = 0; k < 3; k++) step($sformatf("to_err%0d", k), idle, 8'b0000_0001, 0);
    step("err_io_enter", mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0), 8'b1111_0001, 0);
    step("err_io_ack",   mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1), 8'b1111_0011, 0);
    step("err_sticky",   idle, 8'b0000_0001, 0);

    // Reset asserted mid-IO_WAIT between clock edges.
    step("rst_io_enter", mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0), 8'b1111_0001, 0);
    step("rst_io_wait",  idle, 8'b1111_0011, 0);
    #1 reset = 1'b1;
    #1 check8("rst_async", outs(), 8'b0000_0000);
    step("rst_held",    mk(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0), 8'b0000_0000, 0);
    step("rst_release", idle, 8'b0000_0000, 0);
`ifdef HAZARD_PERF_EN
    check16("rst_stallCount", stallCount, 0);
`endif

    // Randomised traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      r = mk(($urandom_range(99) == 0), ($urandom_range(5) == 0), 1'($urandom),
             ($urandom_range(2) == 0), 4'($urandom_range(3)), 4'($urandom_range(3)),
             4'($urandom_range(3)), ($urandom_range(9) == 0), ($urandom_range(5) == 0));
      step($sformatf("rnd%0d", k), r, 8'b0, 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Pipeline sequencing controller for the 5-stage processor (F, D, E, M, WB). It generates the stall and flush enables for the stage flip-flops.
- Load-use stalls: checked against the instruction in Decode.
- Branch flushes: triggered when the condition unit resolves a taken branch in Execute.
- IO handshake: a multi-cycle freeze while the IO port acknowledges an instruction flagged outFlagIO in Memory.
Sits beside `controller`, consuming its registered per-stage outputs.

Parameters:
- REGADDRWIDTH, 4, register-address width of rs1/rs2/rd fields.
- FLUSHCYCLES, 1, total cycles flushD is held after a taken branch (≥1).
- IOTIMEOUT, 255, max cycles waiting for ioAck before abort (≥1, counter width = $clog2(IOTIMEOUT+1)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- takeBranchE  in  1  taken-branch from condition unit (Execute).
- writeEnableE  in  1  register-write enable of the Execute instruction.
- resultSelectorWBE  in  1  1 = Execute instruction is a memory load.
- destRegE  in  REGADDRWIDTH  rd of the Execute instruction.
- srcReg1D  in  REGADDRWIDTH  rs1 of the Decode instruction.
- srcReg2D  in  REGADDRWIDTH  rs2 of the Decode instruction.
- outFlagIOM  in  1  Memory-stage instruction drives the IO port.
- ioAck  in  1  IO peripheral accepted the transfer.
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register.
- flushD, flushE  out  1 each  clear the corresponding pipeline register to a bubble.
- ioReq  out  1  registered request to the IO peripheral.
- ioTimeoutErr  out  1  sticky error, set on IO timeout.

Behaviour:
- Reset (async, active-high): state=RUN, counters=0, ioReq=0, ioTimeoutErr=0. All stall/flush outputs are 0 while reset is asserted.
- States: RUN, FLUSH, IO_WAIT. Stall/flush outputs are Mealy (combinational from state plus inputs). ioReq, counters and error are registered.

RUN, evaluated in priority order:
1. outFlagIOM=1:
   - stallF/D/E/M=1 in the same cycle; no flush.
   - Next state IO_WAIT, ioReq<=1, timer<=0.
   - takeBranchE and load-use are ignored this cycle (the branch is re-evaluated after the freeze).
2. takeBranchE=1:
   - flushD=flushE=1 in the same cycle; no stall.
   - If FLUSHCYCLES>1: next state FLUSH, cnt<=FLUSHCYCLES-1. Otherwise stay in RUN.
   - A concurrent load-use hazard is suppressed, because the Decode instruction is wrong-path.
3. Load-use: resultSelectorWBE & writeEnableE & (destRegE==srcReg1D | destRegE==srcReg2D):
   - stallF=stallD=1, flushE=1 for exactly one cycle; stay in RUN.
   - Next cycle the load is in M and the condition clears naturally.
4. Otherwise all outputs are 0.

FLUSH:
- flushD=1 each cycle; cnt decrements; exit to RUN when cnt==1.
- A takeBranchE arriving here restarts the flush: flushE=1 and cnt<=FLUSHCYCLES-1.
- outFlagIOM arriving here has priority as in RUN.

IO_WAIT:
- stallF/D/E/M=1 and ioReq=1 every cycle.
- If ioAck=1: ioReq<=0, next RUN; the pipeline is released the following cycle.
- Else timer increments. When timer==IOTIMEOUT-1 without ack: ioTimeoutErr<=1, ioReq<=0, next RUN (transfer dropped).
- ioAck in the same cycle as the timeout is treated as success; no error.
- ioAck outside IO_WAIT is ignored.

General rules:
- ioTimeoutErr is cleared only by reset.
- Reset mid-IO_WAIT or mid-FLUSH returns immediately to RUN with ioReq=0.
- Latency: hazard outputs are 0-cycle (same cycle as the inputs); ioReq rises 1 cycle after outFlagIOM.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds output ports stallCount[15:0] and flushCount[15:0].
  - Saturating counters, reset to 0.
  - stallCount increments on each cycle with stallF=1.
  - flushCount increments on each cycle with flushD|flushE=1.
  - Both hold at 16'hFFFF.
- Undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Package `pipeline_pkg`:
  - typedef enum logic [1:0] {RUN, FLUSH, IO_WAIT} hazard_state_t.
  - localparam REGADDRWIDTH default 4.
  - localparam IO_TIMEOUT_DEFAULT=255.
- Sub-module `io_wait_timer`: timer counter, ack/timeout compare and sticky error; instantiated once.

Test Plan:
- Load-use: E = load, writeEnableE=1, destRegE=3; D srcReg2D=3 → stallF=stallD=flushE=1 for exactly 1 cycle, then all 0.
- Branch: takeBranchE=1 with FLUSHCYCLES=2 → flushD=flushE=1 at t0; flushD=1, flushE=0 at t1; all 0 at t2.
- Branch with concurrent load-use (destRegE=5, srcReg1D=5) → flush only; stallF=0.
- IO: outFlagIOM=1 at t0, ioAck=1 at t4 → stalls=1 for t0..t4, ioReq=1 for t1..t4, all 0 at t5, ioTimeoutErr=0.
- Timeout with IOTIMEOUT=8 and no ack → ioTimeoutErr=1 after 8 cycles in IO_WAIT; stays 1 until reset.
- Reset asserted mid-IO_WAIT → ioReq, stalls and state return to 0/RUN asynchronously. With HAZARD_PERF_EN, stallCount reads 0 after release.
